seq_detector_prog: RTL and testbench
====================================

Name: seq_detector_prog

Overview:
Programmable serial bit-pattern detector, the parametrised successor to our fixed 4-bit detector FSM. Pattern, length (1..MAX_LEN) and overlap mode are loaded at runtime. Input bits are valid-qualified. Outputs are a registered single-cycle detect pulse, a partial-match progress indicator (generalised FSM state) and a saturating match counter. The block sits on a serial receive path, ahead of framing/control logic that keys on sync words.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
COUNT_W, 8, width of match counter
DEFAULT_PATTERN, 8'b0000_0001, pattern after reset (MAX_LEN bits, LSB-aligned)
DEFAULT_LEN, 4, pattern length after reset (1..MAX_LEN)
DEFAULT_OVERLAP, 1, overlap mode after reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
bit_valid  in  1  qualifies bit_in this cycle
bit_in  in  1  serial data bit
load  in  1  capture pattern_in/len_in/overlap_in this cycle
pattern_in  in  MAX_LEN  new pattern, LSB-aligned; bit len-1 is first bit expected
len_in  in  LEN_W  new length; LEN_W = $clog2(MAX_LEN+1)
overlap_in  in  1  1 = overlapping matches allowed
count_clr  in  1  synchronous clear of match_count
detect  out  1  one-cycle pulse, cycle after the completing bit
progress  out  LEN_W  length of current partial match (0..len-1)
match_count  out  COUNT_W  saturating count of detects
busy  out  1  progress != 0

Behaviour:
- Reset (async): history=0, fill=0, cfg=DEFAULT_*, detect=0, progress=0, match_count=0, busy=0.
- Config regs: pat_q, len_q, ovl_q. On load: len_in=0 -> len_q=1; len_in>MAX_LEN -> len_q=MAX_LEN. Load clears history, fill and progress. The detect register updates as in any cycle with no valid bit (it goes to 0).
- load and bit_valid in the same cycle: load wins, bit dropped.
- History: on accepted bit, hist <= {hist[MAX_LEN-2:0], bit_in}; fill <= min(fill+1, MAX_LEN). The most recent bit is compared with pat_q[0].
- Match: hit = accepted bit AND fill_next>=len_q AND hist_next[len_q-1:0]==pat_q[len_q-1:0]. Bits above len_q are ignored.
- detect <= hit (registered, latency 1 cycle after the completing bit). Deasserts next cycle unless another hit occurs.
- Overlap mode on hit: ovl_q=1 keeps history, so progress = longest proper border. ovl_q=0 clears fill to 0, so progress=0 and the next match needs len_q fresh bits.
- progress (registered): largest k<len_q with k<=fill_next and hist_next[k-1:0]==pat_q[len_q-1:len_q-k]; 0 if none. It holds when bit_valid=0.
- bit_valid=0: history, fill, progress and count hold; detect goes to 0.
- match_count: +1 per hit, saturates at 2^COUNT_W-1. count_clr with a simultaneous hit gives match_count=0, and detect still pulses.
- Reset mid-stream aborts immediately, with no detect for a partial pattern.
- Config is sampled only on load. pattern_in/len_in are don't-care otherwise.

Decomposition:
- seq_det_pkg holds the LEN_W helper function, the clamp_len function, and DEFAULT_* constants.
- Sub-module seq_det_border: combinational. Inputs are hist_next, fill_next, pat_q and len_q; outputs are hit and progress_next (loop over k=1..MAX_LEN-1). The top holds the registers, config, counter and control.

Test Plan:
1. Reset defaults (pattern 0001, len 4, overlap), stream 0,0,0,1 with bit_valid every cycle -> detect=1 exactly one cycle after 4th bit, match_count=1, progress 1,2,3,0.
2. Load pattern 101, len 3, overlap=1, stream 1,0,1,0,1 -> detect after bits 3 and 5, count=2. Reload with overlap=0, same stream -> detect after bit 3 only, count=3.
3. Pattern 0001 with bit_valid gaps (0,gap,0,gap,gap,0,1) -> detect one cycle after the final 1, progress holds across gaps.
4. load asserted on the same cycle as a valid completing bit -> bit dropped, no detect, progress=0. len_in=0 -> len_q=1; len_in=15 (MAX_LEN=8) -> len_q=8.
5. COUNT_W=2, pattern 1 len 1, eight consecutive 1s -> 8 detect pulses, match_count saturates at 3. count_clr coincident with a hit -> count=0, detect=1.
6. Async reset after 3 bits of 0001 -> outputs zero immediately, and the following 1 gives no detect.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared helpers and reset defaults for the programmable sequence detector.
package seq_det_pkg;

  // Reset-time configuration (pattern is LSB-aligned, 8 bits wide here).
  localparam logic [7:0]  DEFAULT_PATTERN_C = 8'b0000_0001;
  localparam int unsigned DEFAULT_LEN_C     = 4;
  localparam logic        DEFAULT_OVERLAP_C = 1'b1;

  // Width needed to hold a length value in the range 0..max_len.
  function automatic int unsigned len_w(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

  // Legalise a requested pattern length into 1..max_len.
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_len);
    if (len == 0)
      return 1;
    else if (len > max_len)
      return max_len;
    else
      return len;
  endfunction

endpackage

// File: rtl/seq_det_border.sv
// Combinational match and partial-match (border) evaluation on the
// history as it will look after the current bit is shifted in.
module seq_det_border
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 4
) (
  input  logic [MAX_LEN-1:0] hist_next_i,
  input  logic [LEN_W-1:0]   fill_next_i,
  input  logic [MAX_LEN-1:0] pat_i,
  input  logic [LEN_W-1:0]   len_i,
  output logic               hit_o,
  output logic [LEN_W-1:0]   progress_next_o
);

  logic [MAX_LEN-1:0] len_mask;
  logic [MAX_LEN-1:0] k_mask;
  logic [MAX_LEN-1:0] aligned;

  // Full match: low len bits of history equal the low len bits of the
  // pattern. For len == MAX_LEN the shifted one wraps to zero and the
  // subtraction yields an all-ones mask.
  always_comb begin
    len_mask = (MAX_LEN'(1) << len_i) - MAX_LEN'(1);
    hit_o    = (fill_next_i >= len_i) &&
               (((hist_next_i ^ pat_i) & len_mask) == '0);
  end

  // Longest proper prefix of the pattern that ends the history: the
  // top k pattern bits are shifted down to line up with the newest k
  // history bits. Ascending k, so the last qualifying k wins.
  always_comb begin
    progress_next_o = '0;
    k_mask          = '0;
    aligned         = '0;
    for (int unsigned k = 1; k < MAX_LEN; k++) begin
      k_mask  = (MAX_LEN'(1) << k) - MAX_LEN'(1);
      aligned = pat_i >> (32'(len_i) - k);
      if ((k < 32'(len_i)) && (k <= 32'(fill_next_i)) &&
          (((hist_next_i ^ aligned) & k_mask) == '0))
        progress_next_o = LEN_W'(k);
    end
  end

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable serial bit-pattern detector: runtime pattern/length/overlap,
// valid-qualified input, registered detect pulse, progress and match count.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN                 = 8,
  parameter int unsigned COUNT_W                 = 8,
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN  = MAX_LEN'(DEFAULT_PATTERN_C),
  parameter int unsigned DEFAULT_LEN             = DEFAULT_LEN_C,
  parameter logic DEFAULT_OVERLAP                = DEFAULT_OVERLAP_C,
  localparam int unsigned LEN_W                  = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               bit_valid,
  input  logic               bit_in,
  input  logic               load,
  input  logic [MAX_LEN-1:0] pattern_in,
  input  logic [LEN_W-1:0]   len_in,
  input  logic               overlap_in,
  input  logic               count_clr,
  output logic               detect,
  output logic [LEN_W-1:0]   progress,
  output logic [COUNT_W-1:0] match_count,
  output logic               busy
);

  localparam logic [LEN_W-1:0] RST_LEN  = LEN_W'(clamp_len(DEFAULT_LEN, MAX_LEN));
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

  // Configuration
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;

  // Stream state
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;

  // Registered outputs
  logic               detect_q;
  logic [LEN_W-1:0]   progress_q;
  logic [COUNT_W-1:0] match_count_q;

  logic               accept;
  logic               hit_raw;
  logic               hit;
  logic [LEN_W-1:0]   progress_nx;

  // A load in the same cycle as a valid bit drops the bit.
  assign accept = bit_valid & ~load;
  assign hit    = accept & hit_raw;

  // Next history/fill as seen by the matcher for an accepted bit.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (accept) begin
      hist_d = {hist_q[MAX_LEN-2:0], bit_in};
      fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + LEN_W'(1);
    end
  end

  seq_det_border #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_border (
    .hist_next_i     (hist_d),
    .fill_next_i     (fill_d),
    .pat_i           (pat_q),
    .len_i           (len_q),
    .hit_o           (hit_raw),
    .progress_next_o (progress_nx)
  );

  // Config capture, history shift, detect and progress registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q      <= DEFAULT_PATTERN;
      len_q      <= RST_LEN;
      ovl_q      <= DEFAULT_OVERLAP;
      hist_q     <= '0;
      fill_q     <= '0;
      detect_q   <= 1'b0;
      progress_q <= '0;
    end else if (load) begin
      pat_q      <= pattern_in;
      len_q      <= LEN_W'(clamp_len(32'(len_in), MAX_LEN));
      ovl_q      <= overlap_in;
      hist_q     <= '0;
      fill_q     <= '0;
      detect_q   <= 1'b0;
      progress_q <= '0;
    end else if (accept) begin
      hist_q   <= hist_d;
      detect_q <= hit;
      // Non-overlap mode forgets the matched bits by emptying the fill,
      // so the next match has to be built from fresh bits.
      if (hit && !ovl_q) begin
        fill_q     <= '0;
        progress_q <= '0;
      end else begin
        fill_q     <= fill_d;
        progress_q <= progress_nx;
      end
    end else begin
      detect_q <= 1'b0;
    end
  end

  // Saturating match counter; clear has priority over a coincident hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      match_count_q <= '0;
    else if (count_clr)
      match_count_q <= '0;
    else if (hit && (match_count_q != '1))
      match_count_q <= match_count_q + COUNT_W'(1);
  end

  assign detect      = detect_q;
  assign progress    = progress_q;
  assign match_count = match_count_q;
  assign busy        = |progress_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed scoreboard bench for seq_detector_prog (MAX_LEN=8, COUNT_W=2).
module tb_seq_detector_prog;

  logic       clk = 1'b0;
  logic       reset;
  logic       bit_valid;
  logic       bit_in;
  logic       load;
  logic [7:0] pattern_in;
  logic [3:0] len_in;
  logic       overlap_in;
  logic       count_clr;
  logic       detect;
  logic [3:0] progress;
  logic [1:0] match_count;
  logic       busy;

  seq_detector_prog #(
    .MAX_LEN (8),
    .COUNT_W (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .load        (load),
    .pattern_in  (pattern_in),
    .len_in      (len_in),
    .overlap_in  (overlap_in),
    .count_clr   (count_clr),
    .detect      (detect),
    .progress    (progress),
    .match_count (match_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       det;
    logic [3:0] prog;
    logic [1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic push_exp(input logic d, input logic [3:0] p, input logic [1:0] c);
    exp_t e;
    e.det  = d;
    e.prog = p;
    e.cnt  = c;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb_q.pop_front();
    checks++;
    assert (detect === e.det) else begin
      failures++;
      $error("FAIL %s detect: got %0b want %0b", tag, detect, e.det);
    end
    checks++;
    assert (progress === e.prog) else begin
      failures++;
      $error("FAIL %s progress: got %0d want %0d", tag, progress, e.prog);
    end
    checks++;
    assert (match_count === e.cnt) else begin
      failures++;
      $error("FAIL %s match_count: got %0d want %0d", tag, match_count, e.cnt);
    end
    checks++;
    assert (busy === (e.prog != 4'd0)) else begin
      failures++;
      $error("FAIL %s busy: got %0b want %0b", tag, busy, (e.prog != 4'd0));
    end
  endtask

  // Drive one cycle of stimulus, expect given outputs after the edge.
  task automatic drive(input logic v, input logic b, input logic ld,
                       input logic [7:0] pat, input logic [3:0] len,
                       input logic ovl, input logic clr,
                       input logic d, input logic [3:0] p, input logic [1:0] c,
                       input string tag);
    bit_valid  = v;
    bit_in     = b;
    load       = ld;
    pattern_in = pat;
    len_in     = len;
    overlap_in = ovl;
    count_clr  = clr;
    push_exp(d, p, c);
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  task automatic bit_step(input logic v, input logic b, input logic d,
                          input logic [3:0] p, input logic [1:0] c, input string tag);
    drive(v, b, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, d, p, c, tag);
  endtask

  task automatic clr_step(input logic [3:0] p, input string tag);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, p, 2'd0, tag);
  endtask

  task automatic load_step(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                           input logic v, input logic b, input logic [1:0] c,
                           input string tag);
    drive(v, b, 1'b1, pat, len, ovl, 1'b0, 1'b0, 4'd0, c, tag);
  endtask

  task automatic reset_pulse(input string tag);
    reset = 1'b1;
    #2;
    push_exp(1'b0, 4'd0, 2'd0);
    pop_check(tag);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    bit_valid  = 1'b0;
    bit_in     = 1'b0;
    load       = 1'b0;
    pattern_in = '0;
    len_in     = '0;
    overlap_in = 1'b0;
    count_clr  = 1'b0;
    reset_pulse("reset");

    // 1: default pattern 0001, len 4, overlap
    bit_step(1, 0, 0, 4'd1, 2'd0, "t1_b1");
    bit_step(1, 0, 0, 4'd2, 2'd0, "t1_b2");
    bit_step(1, 0, 0, 4'd3, 2'd0, "t1_b3");
    bit_step(1, 1, 1, 4'd0, 2'd1, "t1_b4");
    bit_step(0, 0, 0, 4'd0, 2'd1, "t1_idle");

    // 2: pattern 101 with and without overlap
    clr_step(4'd0, "t2_clr");
    load_step(8'b101, 4'd3, 1'b1, 0, 0, 2'd0, "t2_load_ovl");
    bit_step(1, 1, 0, 4'd1, 2'd0, "t2o_b1");
    bit_step(1, 0, 0, 4'd2, 2'd0, "t2o_b2");
    bit_step(1, 1, 1, 4'd1, 2'd1, "t2o_b3");
    bit_step(1, 0, 0, 4'd2, 2'd1, "t2o_b4");
    bit_step(1, 1, 1, 4'd1, 2'd2, "t2o_b5");
    load_step(8'b101, 4'd3, 1'b0, 0, 0, 2'd2, "t2_load_novl");
    bit_step(1, 1, 0, 4'd1, 2'd2, "t2n_b1");
    bit_step(1, 0, 0, 4'd2, 2'd2, "t2n_b2");
    bit_step(1, 1, 1, 4'd0, 2'd3, "t2n_b3");
    bit_step(1, 0, 0, 4'd0, 2'd3, "t2n_b4");
    bit_step(1, 1, 0, 4'd1, 2'd3, "t2n_b5");

    // 3: default pattern with bit_valid gaps (bit_in=1 during gaps is ignored)
    reset_pulse("t3_reset");
    bit_step(1, 0, 0, 4'd1, 2'd0, "t3_b1");
    bit_step(0, 1, 0, 4'd1, 2'd0, "t3_gap1");
    bit_step(1, 0, 0, 4'd2, 2'd0, "t3_b2");
    bit_step(0, 1, 0, 4'd2, 2'd0, "t3_gap2");
    bit_step(0, 1, 0, 4'd2, 2'd0, "t3_gap3");
    bit_step(1, 0, 0, 4'd3, 2'd0, "t3_b3");
    bit_step(1, 1, 1, 4'd0, 2'd1, "t3_b4");
    bit_step(0, 0, 0, 4'd0, 2'd1, "t3_idle");

    // 4: load collides with a completing bit; length clamping
    bit_step(1, 0, 0, 4'd1, 2'd1, "t4_b1");
    bit_step(1, 0, 0, 4'd2, 2'd1, "t4_b2");
    bit_step(1, 0, 0, 4'd3, 2'd1, "t4_b3");
    load_step(8'b0001, 4'd4, 1'b1, 1, 1, 2'd1, "t4_load_drop");
    bit_step(1, 1, 0, 4'd0, 2'd1, "t4_after_drop");
    load_step(8'h01, 4'd0, 1'b1, 0, 0, 2'd1, "t4_len0");
    bit_step(1, 1, 1, 4'd0, 2'd2, "t4_len1_hit");
    bit_step(1, 0, 0, 4'd0, 2'd2, "t4_len1_miss");
    load_step(8'hAA, 4'd15, 1'b1, 0, 0, 2'd2, "t4_len15");
    for (int i = 0; i < 7; i++)
      bit_step(1, ((i % 2) == 0), 0, 4'(i + 1), 2'd2, "t4_len8_prefix");
    bit_step(1, 0, 1, 4'd6, 2'd3, "t4_len8_hit");

    // 5: single-bit pattern, counter saturation, clear vs hit
    load_step(8'h01, 4'd1, 1'b1, 0, 0, 2'd3, "t5_load");
    clr_step(4'd0, "t5_clr");
    for (int i = 0; i < 8; i++)
      bit_step(1, 1, 1, 4'd0, (i < 3) ? 2'(i + 1) : 2'd3, "t5_ones");
    drive(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 4'd0, 2'd0, "t5_clr_hit");
    bit_step(1, 0, 0, 4'd0, 2'd0, "t5_zero");

    // 6: asynchronous reset mid-pattern restores defaults and aborts
    reset_pulse("t6_reset");
    bit_step(1, 0, 0, 4'd1, 2'd0, "t6_b1");
    bit_step(1, 0, 0, 4'd2, 2'd0, "t6_b2");
    bit_step(1, 0, 0, 4'd3, 2'd0, "t6_b3");
    #2;
    reset = 1'b1;
    #1;
    push_exp(1'b0, 4'd0, 2'd0);
    pop_check("t6_async");
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bit_step(1, 1, 0, 4'd0, 2'd0, "t6_post");
    bit_step(0, 0, 0, 4'd0, 2'd0, "t6_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
